// File: rtl/mem_stage_sram_if.sv
// External 16-bit asynchronous SRAM bus between the memory stage and the SRAM.
// Latency: none, wires only.
// Backpressure: none; the SRAM answers within the wait-state window set by the master.
//
// Ports (signals):
//   sram_addr    half-word address      master -> sram
//   sram_dq_out  write data             master -> sram
//   sram_dq_in   read data              sram -> master
//   sram_dq_oe   1 = master drives data master -> sram
//   sram_we_n    active-low write       master -> sram
//   sram_oe_n    active-low read enable master -> sram
interface mem_stage_sram_if;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    modport master (
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
        output sram_we_n,
        output sram_oe_n,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
        input  sram_we_n,
        input  sram_oe_n,
        output sram_dq_in
    );
endinterface

// File: rtl/mem_stage_sram.sv
// Pipeline memory stage: 32-bit word loads/stores over a 16-bit SRAM as two half-word phases.
// Latency: a memory op holds ready low for 2*WAIT_CYCLES+3 cycles, then one DONE cycle with ready high.
// Backpressure: ready drops combinationally on a request and stays low while the access is in flight.
//
// Ports:
//   clk, rst                 pipeline clock, synchronous active-high reset
//   WB_EN, MEM_R, MEM_W      control from execute (MEM_R wins if both requests are set)
//   ALU_res, val_rm, dest    byte address / ALU result, store data, destination register
//   WB_EN_out, MEM_R_out,
//   dest_out, ALU_res_out    passthroughs to the MEM/WB register (WB_EN gated by ready)
//   mem_data_out             data of the last completed load
//   ready                    0 = freeze every upstream pipeline register
//   sram                     SRAM bus (master side)
module mem_stage_sram #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1      // legal 1..7
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     WB_EN,
    input  logic                     MEM_R,
    input  logic                     MEM_W,
    input  logic [31:0]              ALU_res,
    input  logic [31:0]              val_rm,
    input  logic [3:0]               dest,

    output logic                     WB_EN_out,
    output logic                     MEM_R_out,
    output logic [3:0]               dest_out,
    output logic [31:0]              ALU_res_out,
    output logic [31:0]              mem_data_out,
    output logic                     ready,

    mem_stage_sram_if.master         sram
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] BASE_W     = 32'(BASE_ADDR);
    localparam logic [2:0]  PHASE_LAST = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] lo_q;
    logic [31:0] mem_data_q;

    logic        phase_last;
    logic [16:0] word_idx;
    logic        borrow;

    logic        ready_c;
    logic        oe_n_c;
    logic        we_n_c;
    logic        dq_oe_c;
    logic [17:0] addr_c;
    logic [15:0] dq_out_c;

    // Word index is bits [18:2] of (ALU_res - BASE_ADDR). Only those bits are
    // needed, so subtract the slices and account for the borrow out of bits [1:0].
    assign borrow   = (ALU_res[1:0] < BASE_W[1:0]);
    assign word_idx = ALU_res[18:2] - BASE_W[18:2] - {16'd0, borrow};

    // Counter clears on every phase entry, so the last cycle of a phase is
    // always count == WAIT_CYCLES.
    assign phase_last = (cnt_q == PHASE_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = 3'd0;
        ready_c  = 1'b1;
        oe_n_c   = 1'b1;
        we_n_c   = 1'b1;
        dq_oe_c  = 1'b0;
        addr_c   = 18'd0;
        dq_out_c = 16'd0;

        case (state_q)
            IDLE: begin
                // Read has priority when both requests are presented.
                if (MEM_R) begin
                    state_d = RD_LO;
                    ready_c = 1'b0;
                end else if (MEM_W) begin
                    state_d = WR_LO;
                    ready_c = 1'b0;
                end
            end

            RD_LO: begin
                ready_c = 1'b0;
                oe_n_c  = 1'b0;
                addr_c  = {word_idx, 1'b0};
                if (phase_last) state_d = RD_HI;
                else            cnt_d   = cnt_q + 3'd1;
            end

            RD_HI: begin
                ready_c = 1'b0;
                oe_n_c  = 1'b0;
                addr_c  = {word_idx, 1'b1};
                if (phase_last) state_d = DONE;
                else            cnt_d   = cnt_q + 3'd1;
            end

            WR_LO: begin
                ready_c  = 1'b0;
                dq_oe_c  = 1'b1;
                // Strobe released on the final cycle so data is held past the rising we_n.
                we_n_c   = phase_last;
                addr_c   = {word_idx, 1'b0};
                dq_out_c = val_rm[15:0];
                if (phase_last) state_d = WR_HI;
                else            cnt_d   = cnt_q + 3'd1;
            end

            WR_HI: begin
                ready_c  = 1'b0;
                dq_oe_c  = 1'b1;
                we_n_c   = phase_last;
                addr_c   = {word_idx, 1'b1};
                dq_out_c = val_rm[31:16];
                if (phase_last) state_d = DONE;
                else            cnt_d   = cnt_q + 3'd1;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            lo_q       <= 16'd0;
            mem_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == RD_LO && phase_last) begin
                lo_q <= sram.sram_dq_in;
            end
            // The high half is sampled straight into the result register, which
            // therefore changes exactly on entry to DONE.
            if (state_q == RD_HI && phase_last) begin
                mem_data_q <= {sram.sram_dq_in, lo_q};
            end
        end
    end

    assign ready            = ready_c;
    assign mem_data_out     = mem_data_q;

    assign sram.sram_addr   = addr_c;
    assign sram.sram_dq_out = dq_out_c;
    assign sram.sram_dq_oe  = dq_oe_c;
    assign sram.sram_we_n   = we_n_c;
    assign sram.sram_oe_n   = oe_n_c;

    // Write-back is suppressed while frozen so a stalled op is not retired twice.
    assign WB_EN_out   = WB_EN & ready_c;
    assign MEM_R_out   = MEM_R;
    assign dest_out    = dest;
    assign ALU_res_out = ALU_res;

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

    localparam int W    = 1;
    localparam int BASE = 1024;
    localparam int OPLEN = 2 * W + 4;   // IDLE request cycle, two phases, DONE

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN, MEM_R, MEM_W;
    logic [31:0] ALU_res, val_rm;
    logic [3:0]  dest;
    logic        WB_EN_out, MEM_R_out;
    logic [3:0]  dest_out;
    logic [31:0] ALU_res_out, mem_data_out;
    logic        ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_sram_if sram_bus();

    mem_stage_sram #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .WB_EN        (WB_EN),
        .MEM_R        (MEM_R),
        .MEM_W        (MEM_W),
        .ALU_res      (ALU_res),
        .val_rm       (val_rm),
        .dest         (dest),
        .WB_EN_out    (WB_EN_out),
        .MEM_R_out    (MEM_R_out),
        .dest_out     (dest_out),
        .ALU_res_out  (ALU_res_out),
        .mem_data_out (mem_data_out),
        .ready        (ready),
        .sram         (sram_bus)
    );

    // Asynchronous SRAM model: combinational read, write on edges with we_n low.
    logic [15:0] sram_mem [0:262143];
    assign sram_bus.sram_dq_in = sram_bus.sram_oe_n ? 16'h0000 : sram_mem[sram_bus.sram_addr];
    always @(posedge clk) begin
        if (!sram_bus.sram_we_n) sram_mem[sram_bus.sram_addr] <= sram_bus.sram_dq_out;
    end

    // Reference model: whole 32-bit words keyed by word index, plus the last load.
    logic [31:0] ref_words [int];
    logic [31:0] ref_mem_data;

    function automatic logic [31:0] ref_read(input int idx);
        return ref_words.exists(idx) ? ref_words[idx] : 32'd0;
    endfunction

    function automatic int word_index(input logic [31:0] alu);
        logic [31:0] diff;
        diff = alu - 32'(BASE);
        return int'((diff >> 2) & 32'h1FFFF);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_bus_idle();
        check("we_n_idle",  32'(sram_bus.sram_we_n),  32'd1);
        check("oe_n_idle",  32'(sram_bus.sram_oe_n),  32'd1);
        check("dq_oe_idle", 32'(sram_bus.sram_dq_oe), 32'd0);
    endtask

    // Presents one op starting just after a rising edge; returns just after the
    // rising edge that ends it (after DONE for memory ops).
    task automatic run_op(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] data, input logic [3:0] d);
        int          idx;
        logic [31:0] old_data, new_data;
        logic [17:0] exp_addr;
        int          p;
        logic        hi;
        WB_EN = wb; MEM_R = r; MEM_W = w; ALU_res = alu; val_rm = data; dest = d;

        if (!(r || w)) begin
            @(negedge clk);
            check("ready_alu",   32'(ready),       32'd1);
            check("wb_en_out",   32'(WB_EN_out),   32'(wb));
            check("mem_r_out",   32'(MEM_R_out),   32'd0);
            check("alu_res_out", ALU_res_out,      alu);
            check("dest_out",    32'(dest_out),    32'(d));
            check("mem_data",    mem_data_out,     ref_mem_data);
            check_bus_idle();
            @(posedge clk); #1;
            return;
        end

        idx      = word_index(alu);
        old_data = ref_mem_data;
        new_data = ref_read(idx);

        for (int k = 0; k < OPLEN; k++) begin
            @(negedge clk);
            check("mem_r_out",   32'(MEM_R_out),  32'(r));
            check("alu_res_out", ALU_res_out,     alu);
            check("wb_en_out",   32'(WB_EN_out),  32'(wb && (k == OPLEN - 1)));
            if (k == 0) begin
                check("ready_req", 32'(ready), 32'd0);
                check_bus_idle();
                check("mem_data_hold", mem_data_out, old_data);
            end else if (k == OPLEN - 1) begin
                check("ready_done", 32'(ready), 32'd1);
                check_bus_idle();
                check("mem_data_done", mem_data_out, r ? new_data : old_data);
            end else begin
                hi       = (k >= W + 2);
                p        = hi ? (k - W - 2) : (k - 1);
                exp_addr = {idx[16:0], hi};
                check("ready_busy", 32'(ready),          32'd0);
                check("sram_addr",  32'(sram_bus.sram_addr), 32'(exp_addr));
                check("mem_data_hold", mem_data_out, old_data);
                if (r) begin
                    check("rd_oe_n",  32'(sram_bus.sram_oe_n),  32'd0);
                    check("rd_we_n",  32'(sram_bus.sram_we_n),  32'd1);
                    check("rd_dq_oe", 32'(sram_bus.sram_dq_oe), 32'd0);
                end else begin
                    check("wr_oe_n",  32'(sram_bus.sram_oe_n),  32'd1);
                    check("wr_dq_oe", 32'(sram_bus.sram_dq_oe), 32'd1);
                    check("wr_we_n",  32'(sram_bus.sram_we_n),  32'(p == W));
                    check("wr_dq_out", 32'(sram_bus.sram_dq_out),
                          32'(hi ? data[31:16] : data[15:0]));
                end
            end
            @(posedge clk); #1;
        end

        if (r) ref_mem_data = new_data;
        else   ref_words[idx] = data;
        MEM_R = 1'b0; MEM_W = 1'b0; WB_EN = 1'b0;
    endtask

    initial begin
        logic [31:0] alu, data;
        int          kind;
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
        ref_mem_data = 32'd0;

        rst = 1'b1; WB_EN = 0; MEM_R = 0; MEM_W = 0; ALU_res = 0; val_rm = 0; dest = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready",    32'(ready),        32'd1);
        check("rst_mem_data", mem_data_out,      32'd0);
        check("rst_addr",     32'(sram_bus.sram_addr), 32'd0);
        check_bus_idle();
        @(posedge clk); #1;

        // Directed: store, load back, non-memory op, read/write conflict.
        run_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0);
        check("sram_lo_word", 32'(sram_mem[4]), 32'h0000BEEF);
        check("sram_hi_word", 32'(sram_mem[5]), 32'h0000DEAD);
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd2);
        check("load_deadbeef", mem_data_out, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
        run_op(1'b1, 1'b1, 1'b1, 32'd1024, 32'h12345678, 4'd5);
        run_op(1'b0, 1'b0, 1'b1, 32'd1020, 32'hCAFE0123, 4'd0);   // wraps below base
        run_op(1'b1, 1'b1, 1'b0, 32'd1023, 32'h0, 4'd1);          // same word, low bits ignored

        // Random back-to-back stream.
        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 3));
            alu  = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) alu = 32'(BASE) - 32'(4 * $urandom_range(1, 4));
            data = $urandom;
            case (kind)
                0: run_op(1'($urandom), 1'b0, 1'b0, data, alu, 4'($urandom));
                1: run_op(1'($urandom), 1'b1, 1'b0, alu, data, 4'($urandom));
                2: run_op(1'b0, 1'b0, 1'b1, alu, data, 4'($urandom));
                default: run_op(1'($urandom), 1'b1, 1'b1, alu, data, 4'($urandom));
            endcase
        end

        // Make the result register non-zero, then reset in the second RD_HI cycle.
        run_op(1'b0, 1'b0, 1'b1, 32'd1040, 32'hA5A55A5A, 4'd0);
        run_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd1);
        check("pre_rst_data", mem_data_out, 32'hA5A55A5A);
        MEM_R = 1'b1; ALU_res = 32'd1040;
        for (int k = 0; k <= W + 3; k++) begin
            @(negedge clk);
            if (k == W + 3) check("mid_oe_n", 32'(sram_bus.sram_oe_n), 32'd0);
            if (k < W + 3) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1; MEM_R = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem_data = 32'd0;
        @(negedge clk);
        check("mid_rst_ready",    32'(ready),   32'd1);
        check("mid_rst_mem_data", mem_data_out, 32'd0);
        check_bus_idle();
        @(posedge clk); #1;
        run_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd1);
        check("recover_load", mem_data_out, 32'hA5A55A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
